// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS control unit: FETCH/DECODE/EXEC/MEM/WB sequencer with ready-stall, timeout and illegal-op trap.
// Optional perf counters (cycle_cnt, instret_cnt) are built when MC_CTRL_PERF_EN is defined.
module mc_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 16,
  parameter int unsigned ALUCTRL_W   = 5
`ifdef MC_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W       = 32
`endif
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [5:0]           opcode,
  input  logic [5:0]           func,
  input  logic                 zero,
  input  logic                 mem_ready,
  output logic [3:0]           state,
  output logic                 PCWrite,
  output logic                 IRWrite,
  output logic                 MemRead,
  output logic                 MemWrite,
  output logic                 RegWrite,
  output logic [1:0]           RegDst,
  output logic                 ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [ALUCTRL_W-1:0] ALUCtrl,
  output logic [1:0]           DatatoReg,
  output logic [1:0]           PCSource,
  output logic                 ExtOp,
  output logic                 illegal
`ifdef MC_CTRL_PERF_EN
  ,
  output logic [CNT_W-1:0]     cycle_cnt,
  output logic [CNT_W-1:0]     instret_cnt
`endif
);

  localparam int unsigned TO_W = 8;

  // ALU operation codes, matching the ALUOp_* encodings of the datapath ALU
  localparam logic [4:0] ALUOP_NOP = 5'd0;
  localparam logic [4:0] ALUOP_LUI = 5'd1;
  localparam logic [4:0] ALUOP_ADD = 5'd3;
  localparam logic [4:0] ALUOP_SUB = 5'd4;
  localparam logic [4:0] ALUOP_BNE = 5'd5;
  localparam logic [4:0] ALUOP_SLT = 5'd10;
  localparam logic [4:0] ALUOP_OR  = 5'd13;
  localparam logic [4:0] ALUOP_AND = 5'd14;
  localparam logic [4:0] ALUOP_SLL = 5'd15;
  localparam logic [4:0] ALUOP_SRL = 5'd16;
  localparam logic [4:0] ALUOP_SRA = 5'd17;
  localparam logic [4:0] ALUOP_EQL = 5'd18;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_EXEC   = 4'd2,
    S_MEM    = 4'd3,
    S_WB     = 4'd4,
    S_TRAP   = 4'd15
  } state_e;

  typedef enum logic [3:0] {
    C_NONE, C_ALUR, C_ALUI, C_LW, C_SW, C_BR, C_J, C_JAL, C_JR
  } cls_e;

  state_e          r_state, w_next;
  cls_e            r_cls, w_dec_cls;
  logic [5:0]      r_op, r_fn;
  logic [TO_W-1:0] r_wait;
  logic            w_wait_hit;
  logic            w_shift;
  logic [4:0]      w_alu;

  assign state   = r_state;
  assign illegal = (r_state == S_TRAP);
  assign w_wait_hit = (r_wait == TO_W'(MEM_TIMEOUT - 1));
  assign w_shift = (r_cls == C_ALUR) && ((r_fn == 6'h00) || (r_fn == 6'h02) || (r_fn == 6'h03));

  // Instruction class decode from the live IR fields
  always_comb begin
    w_dec_cls = C_NONE;
    case (opcode)
      6'h00: begin
        case (func)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
          6'h25, 6'h2a, 6'h00, 6'h02, 6'h03: w_dec_cls = C_ALUR;
          6'h08:                             w_dec_cls = C_JR;
          default:                           w_dec_cls = C_NONE;
        endcase
      end
      6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h0f: w_dec_cls = C_ALUI;
      6'h23:                             w_dec_cls = C_LW;
      6'h2b:                             w_dec_cls = C_SW;
      6'h04, 6'h05:                      w_dec_cls = C_BR;
      6'h02:                             w_dec_cls = C_J;
      6'h03:                             w_dec_cls = C_JAL;
      default:                           w_dec_cls = C_NONE;
    endcase
  end

  // ALU operation for the latched instruction
  always_comb begin
    w_alu = ALUOP_ADD;
    case (r_cls)
      C_ALUR: begin
        case (r_fn)
          6'h22, 6'h23: w_alu = ALUOP_SUB;
          6'h24:        w_alu = ALUOP_AND;
          6'h25:        w_alu = ALUOP_OR;
          6'h2a:        w_alu = ALUOP_SLT;
          6'h00:        w_alu = ALUOP_SLL;
          6'h02:        w_alu = ALUOP_SRL;
          6'h03:        w_alu = ALUOP_SRA;
          default:      w_alu = ALUOP_ADD;
        endcase
      end
      C_ALUI: begin
        case (r_op)
          6'h0c:   w_alu = ALUOP_AND;
          6'h0d:   w_alu = ALUOP_OR;
          6'h0a:   w_alu = ALUOP_SLT;
          6'h0f:   w_alu = ALUOP_LUI;
          default: w_alu = ALUOP_ADD;
        endcase
      end
      C_BR:    w_alu = (r_op == 6'h05) ? ALUOP_BNE : ALUOP_EQL;
      default: w_alu = ALUOP_ADD;
    endcase
  end

  // State, latched class and memory wait counter
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_FETCH;
      r_cls   <= C_NONE;
      r_op    <= '0;
      r_fn    <= '0;
      r_wait  <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) begin
        r_cls <= w_dec_cls;
        r_op  <= opcode;
        r_fn  <= func;
      end
      if (w_next != r_state)
        r_wait <= '0;
      else if (((r_state == S_FETCH) || (r_state == S_MEM)) && !mem_ready)
        r_wait <= r_wait + TO_W'(1);
    end
  end

  // Next state; mem_ready takes priority over the timeout
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)       w_next = S_DECODE;
        else if (w_wait_hit) w_next = S_TRAP;
      end
      S_DECODE: w_next = (w_dec_cls == C_NONE) ? S_TRAP : S_EXEC;
      S_EXEC: begin
        case (r_cls)
          C_ALUR, C_ALUI: w_next = S_WB;
          C_LW, C_SW:     w_next = S_MEM;
          default:        w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (mem_ready)       w_next = (r_cls == C_LW) ? S_WB : S_FETCH;
        else if (w_wait_hit) w_next = S_TRAP;
      end
      S_WB:    w_next = S_FETCH;
      S_TRAP:  w_next = S_TRAP;
      default: w_next = S_FETCH;
    endcase
  end

  // Moore control outputs; everything forced low while rst is high
  always_comb begin
    PCWrite   = 1'b0;
    IRWrite   = 1'b0;
    MemRead   = 1'b0;
    MemWrite  = 1'b0;
    RegWrite  = 1'b0;
    RegDst    = 2'd0;
    ALUSrcA   = 1'b0;
    ALUSrcB   = 2'd0;
    ALUCtrl   = ALUCTRL_W'(ALUOP_NOP);
    DatatoReg = 2'd0;
    PCSource  = 2'd0;
    ExtOp     = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'd1;
          ALUCtrl = ALUCTRL_W'(ALUOP_ADD);
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        S_DECODE: begin
          ALUSrcB = 2'd3;
          ExtOp   = 1'b1;
          ALUCtrl = ALUCTRL_W'(ALUOP_ADD);
        end
        S_EXEC: begin
          case (r_cls)
            C_ALUR: begin
              ALUSrcA = 1'b1;
              ALUSrcB = w_shift ? 2'd2 : 2'd0;
              ALUCtrl = ALUCTRL_W'(w_alu);
            end
            C_ALUI: begin
              ALUSrcA = 1'b1;
              ALUSrcB = 2'd2;
              ALUCtrl = ALUCTRL_W'(w_alu);
              ExtOp   = (r_op == 6'h08) || (r_op == 6'h0a);
            end
            C_LW, C_SW: begin
              ALUSrcA = 1'b1;
              ALUSrcB = 2'd2;
              ExtOp   = 1'b1;
              ALUCtrl = ALUCTRL_W'(ALUOP_ADD);
            end
            C_BR: begin
              ALUSrcA  = 1'b1;
              ALUCtrl  = ALUCTRL_W'(w_alu);
              PCSource = 2'd1;
              PCWrite  = zero;
            end
            C_J: begin
              PCSource = 2'd2;
              PCWrite  = 1'b1;
            end
            C_JAL: begin
              PCSource  = 2'd2;
              PCWrite   = 1'b1;
              RegWrite  = 1'b1;
              RegDst    = 2'd2;
              DatatoReg = 2'd2;
            end
            C_JR: begin
              PCSource = 2'd3;
              PCWrite  = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          MemRead  = (r_cls == C_LW);
          MemWrite = (r_cls == C_SW);
        end
        S_WB: begin
          RegWrite  = 1'b1;
          RegDst    = (r_cls == C_ALUR) ? 2'd1 : 2'd0;
          DatatoReg = (r_cls == C_LW) ? 2'd1 : 2'd0;
        end
        default: ;
      endcase
    end
  end

`ifdef MC_CTRL_PERF_EN
  // Free-running cycle and retired-instruction counters
  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt   <= '0;
      instret_cnt <= '0;
    end else begin
      if (r_state != S_TRAP)
        cycle_cnt <= cycle_cnt + CNT_W'(1);
      if ((w_next == S_FETCH) &&
          ((r_state == S_EXEC) || (r_state == S_MEM) || (r_state == S_WB)))
        instret_cnt <= instret_cnt + CNT_W'(1);
    end
  end
`endif

endmodule

// File: tb/tb_mc_ctrl.sv
// Directed bench for mc_ctrl: per-cycle state and control-vector checks against hand-computed values.
module tb_mc_ctrl;

  localparam logic [4:0] A_NOP = 5'd0;
  localparam logic [4:0] A_ADD = 5'd3;
  localparam logic [4:0] A_BNE = 5'd5;
  localparam logic [4:0] A_OR  = 5'd13;
  localparam logic [4:0] A_SLL = 5'd15;
  localparam logic [4:0] A_EQL = 5'd18;

  logic       clk = 1'b0;
  logic       rst, zero, mem_ready;
  logic [5:0] opcode, func;
  logic [3:0] state;
  logic       PCWrite, IRWrite, MemRead, MemWrite, RegWrite, ALUSrcA, ExtOp, illegal;
  logic [1:0] RegDst, ALUSrcB, DatatoReg, PCSource;
  logic [4:0] ALUCtrl;
  logic [20:0] w_ctl;

  int n_checks = 0;
  int n_fail   = 0;

  logic [20:0] Z, F_RDY, F_NRDY, DEC, MEM_RD, MEM_WR, TRP, EX_MEMOP;

  always #5 clk = ~clk;

  mc_ctrl #(.MEM_TIMEOUT(4), .ALUCTRL_W(5)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .func(func), .zero(zero), .mem_ready(mem_ready),
    .state(state), .PCWrite(PCWrite), .IRWrite(IRWrite), .MemRead(MemRead), .MemWrite(MemWrite),
    .RegWrite(RegWrite), .RegDst(RegDst), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUCtrl(ALUCtrl),
    .DatatoReg(DatatoReg), .PCSource(PCSource), .ExtOp(ExtOp), .illegal(illegal)
  );

  assign w_ctl = {PCWrite, IRWrite, MemRead, MemWrite, RegWrite, RegDst, ALUSrcA, ALUSrcB,
                  ALUCtrl, DatatoReg, PCSource, ExtOp, illegal};

  function automatic logic [20:0] c(input logic pcw, irw, mr, mw, rw, input logic [1:0] rd,
                                    input logic asa, input logic [1:0] asb, input logic [4:0] alu,
                                    input logic [1:0] d2r, pcs, input logic ext, ill);
    return {pcw, irw, mr, mw, rw, rd, asa, asb, alu, d2r, pcs, ext, ill};
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Inputs already driven; check this cycle's state/outputs, then move to just after the next edge
  task automatic cyc(input string tag, input logic [3:0] st, input logic [20:0] ctl);
    #1;
    check_eq({tag, ".state"}, 32'(state), 32'(st));
    check_eq({tag, ".ctl"}, 32'(w_ctl), 32'(ctl));
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    rst = 1'b1;
    @(posedge clk);
    #1;
    cyc(tag, 4'd0, Z);
    rst = 1'b0;
  endtask

  initial begin
    Z        = c(0,0,0,0,0,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,0);
    F_RDY    = c(1,1,1,0,0,2'd0,0,2'd1,A_ADD,2'd0,2'd0,0,0);
    F_NRDY   = c(0,0,1,0,0,2'd0,0,2'd1,A_ADD,2'd0,2'd0,0,0);
    DEC      = c(0,0,0,0,0,2'd0,0,2'd3,A_ADD,2'd0,2'd0,1,0);
    MEM_RD   = c(0,0,1,0,0,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,0);
    MEM_WR   = c(0,0,0,1,0,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,0);
    TRP      = c(0,0,0,0,0,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,1);
    EX_MEMOP = c(0,0,0,0,0,2'd0,1,2'd2,A_ADD,2'd0,2'd0,1,0);

    rst = 1'b1; mem_ready = 1'b1; zero = 1'b0; opcode = 6'h00; func = 6'h20;
    @(posedge clk);
    #1;
    cyc("rst", 4'd0, Z);
    rst = 1'b0;

    // add: 4 cycles
    cyc("add.f", 4'd0, F_RDY);
    cyc("add.d", 4'd1, DEC);
    cyc("add.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd0,A_ADD,2'd0,2'd0,0,0));
    cyc("add.wb", 4'd4, c(0,0,0,0,1,2'd1,0,2'd0,A_NOP,2'd0,2'd0,0,0));

    // lw with three stall cycles in MEM: 8 cycles
    opcode = 6'h23;
    cyc("lw.f", 4'd0, F_RDY);
    cyc("lw.d", 4'd1, DEC);
    cyc("lw.e", 4'd2, EX_MEMOP);
    mem_ready = 1'b0;
    cyc("lw.m1", 4'd3, MEM_RD);
    cyc("lw.m2", 4'd3, MEM_RD);
    cyc("lw.m3", 4'd3, MEM_RD);
    mem_ready = 1'b1;
    cyc("lw.m4", 4'd3, MEM_RD);
    cyc("lw.wb", 4'd4, c(0,0,0,0,1,2'd0,0,2'd0,A_NOP,2'd1,2'd0,0,0));

    // beq taken / not taken, bne taken
    opcode = 6'h04; zero = 1'b1;
    cyc("beq1.f", 4'd0, F_RDY);
    cyc("beq1.d", 4'd1, DEC);
    cyc("beq1.e", 4'd2, c(1,0,0,0,0,2'd0,1,2'd0,A_EQL,2'd0,2'd1,0,0));
    zero = 1'b0;
    cyc("beq0.f", 4'd0, F_RDY);
    cyc("beq0.d", 4'd1, DEC);
    cyc("beq0.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd0,A_EQL,2'd0,2'd1,0,0));
    opcode = 6'h05; zero = 1'b1;
    cyc("bne.f", 4'd0, F_RDY);
    cyc("bne.d", 4'd1, DEC);
    cyc("bne.e", 4'd2, c(1,0,0,0,0,2'd0,1,2'd0,A_BNE,2'd0,2'd1,0,0));
    zero = 1'b0;

    // jal then jr
    opcode = 6'h03;
    cyc("jal.f", 4'd0, F_RDY);
    cyc("jal.d", 4'd1, DEC);
    cyc("jal.e", 4'd2, c(1,0,0,0,1,2'd2,0,2'd0,A_NOP,2'd2,2'd2,0,0));
    opcode = 6'h00; func = 6'h08;
    cyc("jr.f", 4'd0, F_RDY);
    cyc("jr.d", 4'd1, DEC);
    cyc("jr.e", 4'd2, c(1,0,0,0,0,2'd0,0,2'd0,A_NOP,2'd0,2'd3,0,0));

    // sll (shift uses zero-extended immediate path), ori, addi
    func = 6'h00;
    cyc("sll.f", 4'd0, F_RDY);
    cyc("sll.d", 4'd1, DEC);
    cyc("sll.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd2,A_SLL,2'd0,2'd0,0,0));
    cyc("sll.wb", 4'd4, c(0,0,0,0,1,2'd1,0,2'd0,A_NOP,2'd0,2'd0,0,0));
    opcode = 6'h0d;
    cyc("ori.f", 4'd0, F_RDY);
    cyc("ori.d", 4'd1, DEC);
    cyc("ori.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd2,A_OR,2'd0,2'd0,0,0));
    cyc("ori.wb", 4'd4, c(0,0,0,0,1,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,0));
    opcode = 6'h08;
    cyc("addi.f", 4'd0, F_RDY);
    cyc("addi.d", 4'd1, DEC);
    cyc("addi.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd2,A_ADD,2'd0,2'd0,1,0));
    cyc("addi.wb", 4'd4, c(0,0,0,0,1,2'd0,0,2'd0,A_NOP,2'd0,2'd0,0,0));

    // sw: 4 cycles, returns straight to FETCH
    opcode = 6'h2b;
    cyc("sw.f", 4'd0, F_RDY);
    cyc("sw.d", 4'd1, DEC);
    cyc("sw.e", 4'd2, EX_MEMOP);
    cyc("sw.m", 4'd3, MEM_WR);

    // sw whose memory never answers: trap on the 4th wait cycle
    cyc("swto.f", 4'd0, F_RDY);
    cyc("swto.d", 4'd1, DEC);
    cyc("swto.e", 4'd2, EX_MEMOP);
    mem_ready = 1'b0;
    cyc("swto.m1", 4'd3, MEM_WR);
    cyc("swto.m2", 4'd3, MEM_WR);
    cyc("swto.m3", 4'd3, MEM_WR);
    cyc("swto.m4", 4'd3, MEM_WR);
    cyc("swto.trap", 4'd15, TRP);
    mem_ready = 1'b1;
    cyc("swto.hold", 4'd15, TRP);
    do_reset("swto.rst");

    // illegal opcode traps after DECODE and stays there until reset
    opcode = 6'h3f;
    cyc("ill.f", 4'd0, F_RDY);
    cyc("ill.d", 4'd1, DEC);
    cyc("ill.trap", 4'd15, TRP);
    cyc("ill.hold", 4'd15, TRP);
    do_reset("ill.rst");

    // reset in the middle of a sw MEM stall suppresses MemWrite and aborts
    opcode = 6'h2b;
    cyc("abt.f", 4'd0, F_RDY);
    cyc("abt.d", 4'd1, DEC);
    cyc("abt.e", 4'd2, EX_MEMOP);
    mem_ready = 1'b0;
    cyc("abt.m1", 4'd3, MEM_WR);
    rst = 1'b1;
    cyc("abt.rst", 4'd3, Z);
    rst = 1'b0;

    // FETCH timeout: four wait cycles with no ready -> TRAP
    cyc("fto.w1", 4'd0, F_NRDY);
    cyc("fto.w2", 4'd0, F_NRDY);
    cyc("fto.w3", 4'd0, F_NRDY);
    cyc("fto.w4", 4'd0, F_NRDY);
    cyc("fto.trap", 4'd15, TRP);
    do_reset("fto.rst");

    // ready on the 4th wait cycle wins over the timeout
    opcode = 6'h00; func = 6'h20; mem_ready = 1'b0;
    cyc("fok.w1", 4'd0, F_NRDY);
    cyc("fok.w2", 4'd0, F_NRDY);
    cyc("fok.w3", 4'd0, F_NRDY);
    mem_ready = 1'b1;
    cyc("fok.w4", 4'd0, F_RDY);
    cyc("fok.d", 4'd1, DEC);
    cyc("fok.e", 4'd2, c(0,0,0,0,0,2'd0,1,2'd0,A_ADD,2'd0,2'd0,0,0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mc_ctrl.md
Name: mc_ctrl

Overview:
- Multi-cycle control unit for the MIPS datapath.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives per-state Moore control outputs.
- Stalls on a memory ready handshake and traps on illegal opcodes or memory timeout.
- Sits between the instruction register (opcode/func) and the shared-memory multi-cycle datapath; adds jal/jr support.

Parameters:
- MEM_TIMEOUT, 16, max cycles a memory state may wait for mem_ready before trapping; legal range 1..255.
- ALUCTRL_W, 5, width of ALUCtrl; codes taken from ctrl_encode_def.v ALUOp_* macros.
- CNT_W, 32, width of the perf counters (optional feature only).

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- opcode  in  6  IR[31:26]
- func  in  6  IR[5:0]
- zero  in  1  ALU compare result (1 = branch condition true), valid in EXEC
- mem_ready  in  1  memory completes the current access this cycle
- state  out  4  current state: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, TRAP=15
- PCWrite  out  1  load PC
- IRWrite  out  1  load IR
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- RegWrite  out  1  register file write
- RegDst  out  2  0=rt, 1=rd, 2=$31
- ALUSrcA  out  1  0=PC, 1=rs
- ALUSrcB  out  2  0=rt, 1=const 4, 2=ext imm, 3=ext imm<<2
- ALUCtrl  out  ALUCTRL_W  ALU operation
- DatatoReg  out  2  0=ALUOut, 1=MDR, 2=PC
- PCSource  out  2  0=ALU result, 1=ALUOut (branch), 2=jump target, 3=rs (jr)
- ExtOp  out  1  0=zero-extend, 1=sign-extend
- illegal  out  1  sticky trap flag

Behaviour:
- Reset: state=FETCH, illegal=0, timeout counter=0. All strobes (PCWrite, IRWrite, MemRead, MemWrite, RegWrite) are 0 in the reset cycle; selects are 0.
- rst asserted mid-instruction aborts the instruction. No strobe is asserted in the cycle rst is high.
- FETCH:
  - MemRead=1, ALUSrcA=0, ALUSrcB=1, ALUCtrl=ADD, PCSource=0.
  - IRWrite=PCWrite=mem_ready.
  - Leaves for DECODE only on the cycle mem_ready=1.
- DECODE:
  - ALUSrcA=0, ALUSrcB=3, ExtOp=1, ALUCtrl=ADD (branch target precompute).
  - Latches the instruction class from opcode/func into an internal register.
  - Unsupported opcode/func -> TRAP, otherwise -> EXEC.
- EXEC, per class:
  - ALU-R (add, sub, addu, subu, slt, sll, srl, sra, and, or): sll/srl/sra use ALUSrcB=2 with ExtOp=0. Next state WB.
  - ALU-I (addi, andi, ori, slti, lui): ALUSrcB=2. ExtOp=1 for addi/slti, 0 otherwise. Next state WB.
  - lw/sw: ALUCtrl=ADD, ALUSrcB=2, ExtOp=1. Next state MEM.
  - beq/bne: ALUSrcA=1, ALUSrcB=0, ALUCtrl=EQL/BNE, PCSource=1, PCWrite=zero. Next state FETCH.
  - j: PCSource=2, PCWrite=1. Next state FETCH.
  - jal: as j, plus RegWrite=1, RegDst=2, DatatoReg=2. Next state FETCH.
  - jr (R-type func 001000): PCSource=3, PCWrite=1. Next state FETCH.
- MEM:
  - lw asserts MemRead; sw asserts MemWrite. Held until mem_ready.
  - When mem_ready: lw -> WB, sw -> FETCH.
- WB:
  - RegWrite=1 for exactly one cycle, then -> FETCH.
  - ALU-R: RegDst=1. ALU-I: RegDst=0. Both DatatoReg=0.
  - lw: RegDst=0, DatatoReg=1.
- Timeout:
  - The counter increments every FETCH/MEM cycle with mem_ready=0 and clears on state change.
  - Reaching MEM_TIMEOUT -> TRAP.
  - mem_ready in the same cycle the count hits MEM_TIMEOUT wins: normal transition, no trap.
- TRAP: all strobes 0, illegal=1. Held until rst.
- Latency without stalls:
  - 3 cycles: branches, j, jal, jr.
  - 4 cycles: ALU ops, sw.
  - 5 cycles: lw.
  - Each mem_ready=0 cycle adds one.
- Outputs are a pure function of state and the latched class (Moore). zero is the only input used combinationally besides mem_ready.

Optional Feature:
- Macro MC_CTRL_PERF_EN.
- Enabled: adds outputs cycle_cnt and instret_cnt, both CNT_W wide.
  - cycle_cnt increments every cycle not in TRAP.
  - instret_cnt increments on every transition into FETCH from EXEC, MEM or WB.
  - Both clear on rst and wrap modulo 2^CNT_W.
- Disabled: those ports do not exist and no counter logic is generated.

Test Plan:
- rst=1 for 2 cycles, then release with mem_ready=1 and add ($0x00/func 0x20) -> states 0,1,2,4,0. RegWrite=1 only in state 4, with RegDst=1.
- lw (0x23), mem_ready low for 3 cycles in MEM -> 8 cycles total. MemRead held for all MEM cycles, then WB with DatatoReg=1.
- beq (0x04) with zero=1 -> PCWrite=1, PCSource=1 in EXEC. Repeat with zero=0 -> PCWrite=0. Both return to FETCH after 3 cycles.
- jal (0x03) -> EXEC drives RegWrite=1, RegDst=2, DatatoReg=2, PCWrite=1, PCSource=2. Then jr (func 0x08) -> PCSource=3.
- opcode 0x3F -> TRAP after DECODE with illegal=1, strobes 0. Assert rst mid-TRAP -> FETCH, illegal=0.
- MEM_TIMEOUT=4, mem_ready stuck 0 in FETCH -> TRAP on the 4th wait cycle. Same case with mem_ready=1 on that cycle -> DECODE.
